// File: rtl/snes_rom_bridge.sv
// snes_rom_bridge
// Byte-wide bridge from the SNES CPU bus to the CPU port of the SDRAM
// controller. It converts one-cycle access strobes into the controller's
// toggle request/acknowledge handshake and does write-through byte writes.
// A 2-entry, word-granular read buffer with a single LRU bit lets repeated
// fetches from the same 16-bit word complete without touching SDRAM.
//
// Ports:
//   clk, init_n        - clock, synchronous active-low reset
//   flush              - invalidate both buffer entries
//   ce, addr, we, din  - SNES access strobe, byte address, write flag, write byte
//   dout, valid, busy  - read byte, completion pulse, access in progress
//   cpu_req/_ack       - toggle handshake to/from the controller
//   cpu_addr/din/ds/we - registered word address, data, byte lanes, write flag
//   cpu_port           - result register select (victim entry index)
//   cpu_port0/1        - controller result registers
module snes_rom_bridge #(
  parameter int ACK_TO_DATA = 5
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        flush,
  input  logic        ce,
  input  logic [23:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        valid,
  output logic        busy,
  output logic        cpu_req,
  input  logic        cpu_req_ack,
  output logic [22:0] cpu_addr,
  output logic [15:0] cpu_din,
  output logic [1:0]  cpu_ds,
  output logic        cpu_we,
  output logic        cpu_port,
  input  logic [15:0] cpu_port0,
  input  logic [15:0] cpu_port1
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAITD = 2'd2;
  localparam logic [1:0] ST_FILL  = 2'd3;

  localparam logic [7:0] CNT_LOAD = 8'(ACK_TO_DATA - 1);

  // Pick the addressed byte of a word (hi = 1 selects the upper byte).
  function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
    sel_byte = hi ? w[15:8] : w[7:0];
  endfunction

  // Replace one byte of a word, leaving the other lane untouched.
  function automatic logic [15:0] merge_byte(input logic [15:0] w, input logic hi,
                                             input logic [7:0] b);
    merge_byte = hi ? {b, w[7:0]} : {w[15:8], b};
  endfunction

  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic [1:0]  vld_r;
  logic [22:0] tag_r  [2];
  logic [15:0] data_r [2];
  logic        lru_r;
  logic        lsb_r;

  logic [22:0] word_s;
  logic [1:0]  match_s;
  logic [1:0]  hit_s;
  logic [15:0] fill_s;

  assign word_s     = addr[23:1];
  assign match_s[0] = (tag_r[0] == word_s);
  assign match_s[1] = (tag_r[1] == word_s);
  // A flush in the same cycle as a read forces that read to miss.
  assign hit_s      = match_s & vld_r & {2{~flush}};
  assign fill_s     = cpu_port ? cpu_port1 : cpu_port0;

  // Bridge state machine, read buffer and controller request registers.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      vld_r     <= 2'b00;
      tag_r[0]  <= 23'd0;
      tag_r[1]  <= 23'd0;
      data_r[0] <= 16'd0;
      data_r[1] <= 16'd0;
      lru_r     <= 1'b0;
      lsb_r     <= 1'b0;
      dout      <= 8'd0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      // The controller's ack is not reset, so realign the toggle pair and
      // abandon whatever request was in flight.
      cpu_req   <= cpu_req_ack;
      cpu_addr  <= 23'd0;
      cpu_din   <= 16'd0;
      cpu_ds    <= 2'b11;
      cpu_we    <= 1'b0;
      cpu_port  <= 1'b0;
    end else begin
      valid <= 1'b0;
      // A fill in the same cycle sets its own vld bit again below.
      if (flush) begin
        vld_r <= 2'b00;
      end

      case (state_r)
        ST_IDLE: begin
          if (ce) begin
            if (we) begin
              // Write-through: patch any buffered copy now, then go to SDRAM.
              if (match_s[0]) begin
                data_r[0] <= merge_byte(data_r[0], addr[0], din);
              end
              if (match_s[1]) begin
                data_r[1] <= merge_byte(data_r[1], addr[0], din);
              end
              cpu_addr <= word_s;
              cpu_din  <= {din, din};
              cpu_ds   <= {addr[0], ~addr[0]};
              cpu_we   <= 1'b1;
              cpu_req  <= ~cpu_req;
              busy     <= 1'b1;
              state_r  <= ST_REQ;
            end else if (hit_s[0]) begin
              dout  <= sel_byte(data_r[0], addr[0]);
              valid <= 1'b1;
              lru_r <= 1'b1;
            end else if (hit_s[1]) begin
              dout  <= sel_byte(data_r[1], addr[0]);
              valid <= 1'b1;
              lru_r <= 1'b0;
            end else begin
              // Miss: the LRU entry is the victim and also names the
              // controller result register the data will arrive in.
              lsb_r    <= addr[0];
              cpu_addr <= word_s;
              cpu_din  <= {din, din};
              cpu_ds   <= 2'b11;
              cpu_we   <= 1'b0;
              cpu_port <= lru_r;
              cpu_req  <= ~cpu_req;
              busy     <= 1'b1;
              state_r  <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (cpu_req == cpu_req_ack) begin
            if (cpu_we) begin
              valid   <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r   <= CNT_LOAD;
              state_r <= ST_WAITD;
            end
          end
        end

        ST_WAITD: begin
          if (cnt_r == 8'd0) begin
            state_r <= ST_FILL;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end

        ST_FILL: begin
          data_r[cpu_port] <= fill_s;
          tag_r[cpu_port]  <= cpu_addr;
          vld_r[cpu_port]  <= 1'b1;
          dout             <= sel_byte(fill_s, lsb_r);
          valid            <= 1'b1;
          lru_r            <= ~cpu_port;
          busy             <= 1'b0;
          state_r          <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_rom_bridge.sv
// Scoreboard bench for snes_rom_bridge with a toggle-handshake SDRAM model.
module tb_snes_rom_bridge;

  localparam int A = 5;

  logic        clk = 1'b0;
  logic        init_n;
  logic        flush;
  logic        ce;
  logic [23:0] addr;
  logic        we;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        valid;
  logic        busy;
  logic        cpu_req;
  logic        cpu_req_ack = 1'b0;
  logic [22:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_ds;
  logic        cpu_we;
  logic        cpu_port;
  logic [15:0] cpu_port0 = 16'h0000;
  logic [15:0] cpu_port1 = 16'h0000;

  int checks   = 0;
  int failures = 0;
  int toggles  = 0;
  int vcount   = 0;
  logic trk      = 1'b0;
  logic req_prev = 1'b0;

  logic [8:0]  sb_q [$];
  logic [15:0] ref_mem [256];
  logic [15:0] mem [256];
  logic        loaded = 1'b0;
  logic        m_busy = 1'b0;
  logic [2:0]  m_cnt  = 3'd0;

  snes_rom_bridge #(.ACK_TO_DATA(A)) dut (
    .clk(clk), .init_n(init_n), .flush(flush), .ce(ce), .addr(addr), .we(we),
    .din(din), .dout(dout), .valid(valid), .busy(busy), .cpu_req(cpu_req),
    .cpu_req_ack(cpu_req_ack), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ds(cpu_ds), .cpu_we(cpu_we), .cpu_port(cpu_port),
    .cpu_port0(cpu_port0), .cpu_port1(cpu_port1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [7:0] i);
    if (i == 8'h00) return 16'hA55A;
    return {i ^ 8'h3C, ~i};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [23:0] a);
    logic [15:0] w;
    w = ref_mem[a[8:1]];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM controller model: answers a request toggle after a few cycles.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      loaded <= 1'b1;
    end else if (!m_busy) begin
      if (init_n && (cpu_req != cpu_req_ack)) begin
        m_busy <= 1'b1;
        m_cnt  <= 3'($urandom_range(1, 5));
      end
    end else if (m_cnt == 3'd0) begin
      m_busy      <= 1'b0;
      cpu_req_ack <= ~cpu_req_ack;
      if (cpu_we) begin
        if (cpu_ds[1]) mem[cpu_addr[7:0]][15:8] <= cpu_din[15:8];
        if (cpu_ds[0]) mem[cpu_addr[7:0]][7:0]  <= cpu_din[7:0];
      end else if (cpu_port) begin
        cpu_port1 <= mem[cpu_addr[7:0]];
        cpu_port0 <= ~mem[cpu_addr[7:0]];
      end else begin
        cpu_port0 <= mem[cpu_addr[7:0]];
        cpu_port1 <= ~mem[cpu_addr[7:0]];
      end
    end else begin
      m_cnt <= m_cnt - 3'd1;
    end
  end

  // Count request toggles and valid pulses.
  always @(negedge clk) begin
    if (trk && (cpu_req !== req_prev)) toggles <= toggles + 1;
    req_prev <= cpu_req;
    if (valid === 1'b1) vcount <= vcount + 1;
  end

  task automatic access(input logic [23:0] a, input logic w, input logic [7:0] d,
                        input logic exp_hit, input int exp_port, input logic fl,
                        input logic ign, input string tag);
    int t0, v0, n, k;
    logic ack0;
    logic [8:0] e;
    t0 = toggles; v0 = vcount; ack0 = cpu_req_ack;
    @(negedge clk);
    addr = a; we = w; din = d; ce = 1'b1; flush = fl;
    if (w) begin
      if (a[0]) ref_mem[a[8:1]][15:8] = d;
      else      ref_mem[a[8:1]][7:0]  = d;
      sb_q.push_back({1'b0, 8'h00});
    end else begin
      sb_q.push_back({1'b1, ref_byte(a)});
    end
    @(negedge clk);
    ce = 1'b0; flush = 1'b0; we = 1'b0;
    if (!exp_hit) begin
      check_eq({tag, "_busy"}, busy, 1);
      check_eq({tag, "_addr"}, cpu_addr, a[23:1]);
      check_eq({tag, "_we"}, cpu_we, w);
      check_eq({tag, "_ds"}, cpu_ds, w ? {a[0], ~a[0]} : 2'b11);
      if (w) check_eq({tag, "_din"}, cpu_din, {d, d});
      if (exp_port >= 0) check_eq({tag, "_port"}, cpu_port, exp_port[0]);
      if (ign) begin
        addr = 24'h008100; we = 1'b1; din = 8'hEE; ce = 1'b1;
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
        check_eq({tag, "_ign_addr"}, cpu_addr, a[23:1]);
        check_eq({tag, "_ign_we"}, cpu_we, w);
      end
      n = 0;
      while (cpu_req_ack == ack0 && n < 64) begin @(negedge clk); n++; end
      check_eq({tag, "_ack"}, cpu_req_ack != ack0, 1);
    end
    k = 0;
    while (valid !== 1'b1 && k < 64) begin @(negedge clk); k++; end
    check_eq({tag, "_lat"}, k, exp_hit ? 0 : (w ? 1 : A + 2));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e[8]) check_eq({tag, "_dout"}, dout, e[7:0]);
    end
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_vcnt"}, vcount - v0, 1);
    check_eq({tag, "_tog"}, toggles - t0, exp_hit ? 0 : 1);
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
    init_n = 1'b0; flush = 1'b0; ce = 1'b0; we = 1'b0; addr = 24'd0; din = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_ds", cpu_ds, 2'b11);
    check_eq("rst_we", cpu_we, 0);
    check_eq("rst_port", cpu_port, 0);
    check_eq("rst_req", cpu_req, cpu_req_ack);
    init_n = 1'b1;
    trk = 1'b1;
    @(negedge clk);

    // Reset while waiting for data: request abandoned, toggle pair realigned.
    v0 = vcount;
    addr = 24'h008000; we = 1'b0; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    n = 0;
    while (cpu_req_ack == 1'b0 && n < 64) begin @(negedge clk); n++; end
    check_eq("rmm_ack", cpu_req_ack, 1);
    @(negedge clk);
    @(negedge clk);
    init_n = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
    check_eq("rmm_req", cpu_req, 1);
    check_eq("rmm_busy", busy, 0);
    repeat (A + 4) @(negedge clk);
    check_eq("rmm_novalid", vcount - v0, 0);

    // Miss then hit on the same word.
    access(24'h008000, 1'b0, 8'h00, 1'b0, 0,  1'b0, 1'b0, "miss_w0");
    access(24'h008001, 1'b0, 8'h00, 1'b1, -1, 1'b0, 1'b0, "hit_w0");
    // LRU replacement: W1, W0, W2 -> W2 evicts W1.
    access(24'h008002, 1'b0, 8'h00, 1'b0, 1,  1'b0, 1'b0, "miss_w1");
    access(24'h008000, 1'b0, 8'h00, 1'b1, -1, 1'b0, 1'b0, "hit_w0b");
    access(24'h008004, 1'b0, 8'h00, 1'b0, 1,  1'b0, 1'b0, "miss_w2");
    access(24'h008001, 1'b0, 8'h00, 1'b1, -1, 1'b0, 1'b0, "hit_w0c");
    access(24'h008002, 1'b0, 8'h00, 1'b0, 1,  1'b0, 1'b0, "miss_w1b");
    // Write-through merge into the buffered W0.
    access(24'h008001, 1'b1, 8'h3C, 1'b0, -1, 1'b0, 1'b0, "wr_odd");
    access(24'h008001, 1'b0, 8'h00, 1'b1, -1, 1'b0, 1'b0, "hit_merged");
    access(24'h008000, 1'b0, 8'h00, 1'b1, -1, 1'b0, 1'b0, "hit_even");
    // Flush coinciding with a read of a buffered word.
    access(24'h008000, 1'b0, 8'h00, 1'b0, 1,  1'b1, 1'b0, "flush_rd");
    // Strobe while busy is ignored.
    access(24'h008006, 1'b0, 8'h00, 1'b0, 0,  1'b0, 1'b1, "ce_busy");
    // Top of the address space.
    access(24'hFFFFFF, 1'b0, 8'h00, 1'b0, 1,  1'b0, 1'b0, "miss_top");
    access(24'hFFFFFE, 1'b0, 8'h00, 1'b1, -1, 1'b0, 1'b0, "hit_top");
    // Write to an unbuffered word, read it back from SDRAM, even-lane merge.
    access(24'h008011, 1'b1, 8'h99, 1'b0, -1, 1'b0, 1'b0, "wr_nobuf");
    access(24'h008011, 1'b0, 8'h00, 1'b0, 0,  1'b0, 1'b0, "rd_wrback");
    access(24'h008010, 1'b1, 8'h77, 1'b0, -1, 1'b0, 1'b0, "wr_even");
    access(24'h008010, 1'b0, 8'h00, 1'b1, -1, 1'b0, 1'b0, "hit_even2");

    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
